// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory
// steps, with a bounded wait on mem_ready and sticky error flags.
module mips_mc_control #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    state_t     w_dstate;
    logic [7:0] r_cnt;
    logic       r_illegal;
    logic       r_timeout;
    logic       w_waiting;
    logic       w_timeout;
    logic       w_illegal;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irw;
    logic [1:0] w_aluop;

    // Wait states hold until mem_ready, bounded by the counter.
    always_comb begin
        w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_timeout = w_waiting && !mem_ready && (r_cnt == CNT_MAX);
        w_illegal = 1'b0;
        w_next    = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = (mem_ready) ? S_DECODE : (w_timeout ? S_FETCH : S_FETCH);
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYP:      w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      w_next = S_MEMRD;
                else if (op == OP_SW) w_next = S_MEMWR;
                else                  w_next = S_FETCH;
            end
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : (w_timeout ? S_FETCH : S_MEMRD);
            S_MEMWR:   w_next = S_FETCH;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
        if (r_state == S_MEMWR && !mem_ready && !w_timeout)
            w_next = S_MEMWR;
    end

    // Counter is only non-zero while stalled, so clearing on every non-stall
    // cycle is equivalent to clearing on entry to a wait state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_waiting && !mem_ready && !w_timeout)
                r_cnt <= r_cnt + 8'd1;
            else
                r_cnt <= '0;
            if (w_illegal) r_illegal <= 1'b1;
            if (w_timeout) r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_dstate  = rst_n ? r_state : S_FETCH;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        w_irw     = 1'b0;
        w_aluop   = 2'b00;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        iord      = 1'b0;
        alusrca   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        case (w_dstate)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irw     = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = !w_timeout;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = 2'b10;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                w_aluop  = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
        irwrite = rst_n & w_irw;
        pcen    = rst_n & (w_pcwrite | (w_branch & zero));
        state   = w_dstate;
        case (w_aluop)
            2'b01:   alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign illegal_op  = r_illegal;
    assign mem_timeout = r_timeout;

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles to wait for mem_ready in any memory state (range 2..255).
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 op  input  6  opcode field, IR[31:26].
REQ-005 funct  input  6  function field, IR[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-008 pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg  output  1 each  datapath enables and selects for the register, mux and memory stages.
REQ-009 alusrcb, pcsrc  output  2 each  ALU operand-B select, next-PC select.
REQ-010 alucontrol  output  3  ALU operation.
REQ-011 state  output  4  current state encoding, for debug.
REQ-012 illegal_op, mem_timeout  output  1 each  sticky error flags.

Function
REQ-013 Moore FSM with states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Encodings 12..15 are unused and go to FETCH.
REQ-014 Transitions:
- FETCH->DECODE when mem_ready=1; otherwise stay in FETCH.
- DECODE by op: 100011/101011->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 001000->ADDIEX; 000010->JEX; any other op->FETCH.
- MEMADR: lw->MEMRD, sw->MEMWR.
- MEMRD->MEMWB when mem_ready=1.
- MEMWR->FETCH when mem_ready=1.
- RTYPEEX->RTYPEWB, ADDIEX->ADDIWB.
- MEMWB, RTYPEWB, BEQEX, ADDIWB and JEX each go to FETCH.
REQ-015 Every output not listed for a state is 0 in that state. Per-state outputs:
- FETCH: alusrcb=01; irwrite=1 and pc write=1 only in the cycle mem_ready=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1, held high until the cycle mem_ready=1 (inclusive).
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pc write=1.
REQ-016 pcen = pcwrite OR (branch AND zero), combinational.
REQ-017 alucontrol decode:
- aluop 00 -> 010.
- aluop 01 -> 110.
- aluop 10, by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, otherwise 010.
REQ-018 Wait counter: cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle the block waits with mem_ready=0.
REQ-019 Timeout: when the counter reaches TIMEOUT-1 with mem_ready still 0, the next state is FETCH, mem_timeout is set, and no irwrite/pcen/memwrite is asserted in that exit cycle.
REQ-020 Timeout boundary: mem_ready=1 in the same cycle the counter reaches TIMEOUT-1 completes normally and does not set mem_timeout.
REQ-021 illegal_op is set in the DECODE cycle that takes the other-op branch.
REQ-022 illegal_op and mem_timeout are sticky; only reset clears them.

Reset
REQ-023 rst_n=0 sampled at a clk edge forces state=FETCH, wait counter=0, illegal_op=0, mem_timeout=0. This holds mid-instruction, including during MEMWR.
REQ-024 While rst_n=0: irwrite, pcen, regwrite and memwrite are 0; the other outputs take their FETCH values.

Verification
REQ-025 lw with mem_ready always 1 -> states 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in state 4; 5 cycles per instruction.
REQ-026 sw, mem_ready low for 3 cycles in MEMWR -> memwrite high for 4 consecutive cycles, then state 0; mem_timeout=0.
REQ-027 beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0.
REQ-028 R-type funct=101010 -> alucontrol=111 in RTYPEEX; RTYPEWB has regdst=1, regwrite=1.
REQ-029 op=111111 -> DECODE returns to FETCH; illegal_op=1 and stays 1 across a following lw until rst_n=0.
REQ-030 TIMEOUT=4, mem_ready held 0 in FETCH -> exit to FETCH after 4 cycles, mem_timeout=1, irwrite never 1. Then rst_n=0 during MEMWR -> memwrite=0 and state=0 on the next edge.
